// File: rtl/money_collector_pkg.sv
// Shared constants and types for the vending payment path.
// Euro amounts are 5-bit even values shared with the change dispenser.
package money_collector_pkg;

  localparam int COIN_VALUE = 2;
  localparam int NOTE_VALUE = 10;
  localparam int MAX_CREDIT = 30;
  localparam int MAX_PRICE  = 28;

  typedef logic [4:0] euro_t;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE,
    REFUND
  } state_t;

endpackage

// File: rtl/money_collector_if.sv
// Bus between the price lookup / money sensors and the collector,
// plus the change-dispenser handshake.
interface money_collector_if;
  import money_collector_pkg::*;

  logic  start;
  euro_t valueToPay;
  logic  coin2In;
  logic  note10In;
  logic  cancel;
  logic  changeAck;
  logic  busy;
  euro_t inputMoney;
  logic  changeValid;
  euro_t changeAmount;
  logic  refund;
  logic  rejectItem;
  logic  priceError;

  modport master (
    output start, valueToPay, coin2In, note10In, cancel, changeAck,
    input  busy, inputMoney, changeValid, changeAmount, refund, rejectItem, priceError
  );

  modport slave (
    input  start, valueToPay, coin2In, note10In, cancel, changeAck,
    output busy, inputMoney, changeValid, changeAmount, refund, rejectItem, priceError
  );

endinterface

// File: rtl/money_collector_credit_accumulator.sv
// Saturation-checked credit update: a note is evaluated first, then a coin
// against the post-note credit; every insert that is not accepted is flagged.
module credit_accumulator
  import money_collector_pkg::*;
(
  input  logic  enable,
  input  euro_t credit,
  input  logic  coin,
  input  logic  note,
  output euro_t credit_next,
  output logic  reject
);

  logic [5:0] after_note;
  logic [5:0] after_coin;
  logic       note_ok;
  logic       coin_ok;

  // One spare bit so the capacity test cannot wrap around.
  always_comb begin
    note_ok    = enable && note && (({1'b0, credit} + 6'(NOTE_VALUE)) <= 6'(MAX_CREDIT));
    after_note = note_ok ? ({1'b0, credit} + 6'(NOTE_VALUE)) : {1'b0, credit};
    coin_ok    = enable && coin && ((after_note + 6'(COIN_VALUE)) <= 6'(MAX_CREDIT));
    after_coin = coin_ok ? (after_note + 6'(COIN_VALUE)) : after_note;
    credit_next = euro_t'(after_coin);
    reject      = (note && !note_ok) || (coin && !coin_ok);
  end

endmodule

// File: rtl/money_collector.sv
// Payment collector: latches the price, accumulates credit, and presents
// change or a cancel refund to the dispenser until it is acknowledged.
module money_collector
  import money_collector_pkg::*;
(
  input logic              clock,
  input logic              reset,
  money_collector_if.slave bus
);

  state_t state;
  state_t state_next;
  euro_t  price;
  euro_t  price_next;
  euro_t  credit;
  euro_t  credit_next;
  euro_t  change;
  euro_t  change_next;
  euro_t  price_even;
  euro_t  acc_credit;
  logic   acc_reject;
  logic   acc_enable;
  logic   reject_reg;
  logic   reject_next;
  logic   price_error_reg;
  logic   price_error_next;

  assign price_even = bus.valueToPay & 5'b11110;
  assign acc_enable = (state == COLLECT) && !bus.cancel;

  credit_accumulator u_accumulator (
    .enable      (acc_enable),
    .credit      (credit),
    .coin        (bus.coin2In),
    .note        (bus.note10In),
    .credit_next (acc_credit),
    .reject      (acc_reject)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:
        if (bus.start && (price_even <= 5'(MAX_PRICE)))
          state_next = (price_even == '0) ? DONE : COLLECT;
      COLLECT:
        if (bus.cancel)                state_next = REFUND;
        else if (acc_credit >= price)  state_next = DONE;
      DONE, REFUND:
        if (bus.changeAck) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outside COLLECT the accumulator is disabled, so any insert shows up as a reject.
  always_comb begin
    price_next       = price;
    credit_next      = credit;
    change_next      = change;
    reject_next      = acc_reject;
    price_error_next = 1'b0;
    case (state)
      IDLE: begin
        reject_next = acc_reject || bus.cancel;
        if (bus.start) begin
          if (price_even > 5'(MAX_PRICE)) begin
            price_error_next = 1'b1;
          end else begin
            price_next  = price_even;
            credit_next = '0;
            change_next = '0;
          end
        end
      end
      COLLECT: begin
        credit_next = acc_credit;
        if (bus.cancel)               change_next = credit;
        else if (acc_credit >= price) change_next = acc_credit - price;
      end
      DONE, REFUND: begin
        if (bus.changeAck) begin
          credit_next = '0;
          change_next = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      price           <= '0;
      credit          <= '0;
      change          <= '0;
      reject_reg      <= 1'b0;
      price_error_reg <= 1'b0;
    end else begin
      price           <= price_next;
      credit          <= credit_next;
      change          <= change_next;
      reject_reg      <= reject_next;
      price_error_reg <= price_error_next;
    end
  end

  assign bus.busy         = (state != IDLE);
  assign bus.inputMoney   = credit;
  assign bus.changeValid  = (state == DONE) || (state == REFUND);
  assign bus.changeAmount = change;
  assign bus.refund       = (state == REFUND);
  assign bus.rejectItem   = reject_reg;
  assign bus.priceError   = price_error_reg;

endmodule
